// File: rtl/fifo_rd_cntrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_cntrl
// Read-side controller of the async FIFO. Lives in the read clock domain, owns
// the binary and Gray read pointers, detects empty against the already
// synchronised Gray write pointer, drives the memory read address and
// prefetches one word into a registered valid/ready output stage.
//
// Ports:
//   i_r_clk      read-domain clock
//   i_rst        asynchronous reset, active-high
//   i_rq2_wptr   Gray write pointer, synchronised into i_r_clk
//   i_rd_data    memory read data (combinational from o_rd_addr)
//   i_rd_ready   consumer accepts o_rd_data this cycle
//   o_rd_addr    memory read address (low bits of binary read pointer)
//   o_rptr_gray  registered Gray read pointer, to the write-domain synchroniser
//   o_empty      memory holds no unread word (output stage excluded)
//   o_rd_valid   o_rd_data holds a word not yet accepted
//   o_rd_data    registered output word
//   o_rd_level   words in memory, excluding output stage (0..2^ADDR_WIDTH)
// -----------------------------------------------------------------------------
module fifo_rd_cntrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  i_r_clk,
    input  logic                  i_rst,
    input  logic [ADDR_WIDTH:0]   i_rq2_wptr,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    input  logic                  i_rd_ready,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    output logic [ADDR_WIDTH:0]   o_rptr_gray,
    output logic                  o_empty,
    output logic                  o_rd_valid,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic [ADDR_WIDTH:0]   o_rd_level
);

    localparam int PW = ADDR_WIDTH + 1;

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int k = PW - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

    logic [PW-1:0]         rbin_r;
    logic [PW-1:0]         rgray_r;
    logic                  valid_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic [PW-1:0]         rbin_next_s;
    logic                  empty_s;
    logic                  pop_s;
    logic                  drain_s;

    // The extra pointer MSB makes full and empty distinguishable, so plain
    // equality of the Gray pointers is an exact empty test.
    assign empty_s = (rgray_r == i_rq2_wptr);
    assign pop_s   = ~empty_s & (~valid_r | i_rd_ready);
    assign drain_s = valid_r & i_rd_ready;

    // Next binary read pointer: advance by one on every pop.
    always_comb begin
        rbin_next_s = rbin_r;
        if (pop_s) begin
            rbin_next_s = rbin_r + PW'(1);
        end else begin
            rbin_next_s = rbin_r;
        end
    end

    // Pointer registers and the one-word output stage.
    always_ff @(posedge i_r_clk or posedge i_rst) begin
        if (i_rst) begin
            rbin_r  <= {PW{1'b0}};
            rgray_r <= {PW{1'b0}};
            valid_r <= 1'b0;
            data_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            rbin_r  <= rbin_next_s;
            // Gray taken from the next binary value so both update together.
            rgray_r <= bin2gray(rbin_next_s);
            if (pop_s) begin
                // Accept-and-pop in one edge replaces the word with no bubble.
                valid_r <= 1'b1;
                data_r  <= i_rd_data;
            end else if (drain_s) begin
                valid_r <= 1'b0;
                data_r  <= data_r;
            end else begin
                valid_r <= valid_r;
                data_r  <= data_r;
            end
        end
    end

    assign o_rd_addr   = rbin_r[ADDR_WIDTH-1:0];
    assign o_rptr_gray = rgray_r;
    assign o_empty     = empty_s;
    assign o_rd_valid  = valid_r;
    assign o_rd_data   = data_r;
    // Conservative: the write pointer is stale by the synchroniser delay.
    assign o_rd_level  = gray2bin(i_rq2_wptr) - rbin_r;

endmodule
